axi_ram_slave: RTL

AXI3 slave backed by on-chip word RAM. Sits directly downstream of cpu_axi and serves its read and write bursts: ICache/DCache line fills, DCache writebacks, and uncached single beats. Used as main memory in simulation and small FPGA builds. Read and write channels are independent and may be active at the same time.

---
 rtl/axi_pkg.sv | 17 +
 rtl/axi_ram_slave_mem.sv | 24 ++
 rtl/axi_ram_slave.sv | 129 ++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// axi_pkg: burst/response encodings, FSM states and the beat address step
// shared by the AXI RAM slave.
package axi_pkg;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_BURST} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    // WRAP is served as INCR; only FIXED holds the address.
    function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [1:0] b, input logic [2:0] s);
        return (b == BURST_FIXED) ? a : a + (32'd1 << s);
    endfunction
endpackage

// File: rtl/axi_ram_slave_mem.sv
// axi_ram_slave_mem: simple dual-port word RAM with byte-enabled write and registered read
module axi_ram_slave_mem #(
  parameter int ADDR_WIDTH = 14,
  parameter     INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [3:0]            i_wstrb,
  input  logic [31:0]           i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [31:0]           o_rdata
);
  logic [31:0] r_mem [2**ADDR_WIDTH];
  logic [31:0] r_rdata;
  initial for (int i = 0; i < 2**ADDR_WIDTH; i++) r_mem[i] = '0;
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (i_we && i_wstrb[i]) r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
    if (i_re) r_rdata <= r_mem[i_raddr];
  end
  assign o_rdata = r_rdata;
endmodule

// File: rtl/axi_ram_slave.sv
// axi_ram_slave: AXI3 slave over on-chip word RAM with independent read and
// write burst engines.
module axi_ram_slave
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 14,
    parameter     INIT_FILE  = ""
) (
    input  logic        clk,
    input  logic        rset,
    input  logic [31:0] axi_araddr,
    input  logic [1:0]  axi_arburst,
    input  logic [3:0]  axi_arid,
    input  logic [7:0]  axi_arlen,
    input  logic [2:0]  axi_arsize,
    input  logic        axi_arvalid,
    output logic        axi_arready,
    output logic [31:0] axi_rdata,
    output logic [3:0]  axi_rid,
    output logic [1:0]  axi_rresp,
    output logic        axi_rlast,
    output logic        axi_rvalid,
    input  logic        axi_rready,
    input  logic [31:0] axi_awaddr,
    input  logic [1:0]  axi_awburst,
    input  logic [3:0]  axi_awid,
    input  logic [7:0]  axi_awlen,
    input  logic [2:0]  axi_awsize,
    input  logic        axi_awvalid,
    output logic        axi_awready,
    input  logic [31:0] axi_wdata,
    input  logic [3:0]  axi_wstrb,
    input  logic        axi_wlast,
    input  logic [3:0]  axi_wid,
    input  logic        axi_wvalid,
    output logic        axi_wready,
    output logic [3:0]  axi_bid,
    output logic [1:0]  axi_bresp,
    output logic        axi_bvalid,
    input  logic        axi_bready
);
    r_state_t r_rstate;
    w_state_t r_wstate;
    logic [31:0] r_araddr, r_awaddr;
    logic [3:0]  r_rid, r_bid;
    logic [7:0]  r_rlen, r_rcnt, r_wlen;
    logic [8:0]  r_wcnt;
    logic [2:0]  r_rsize, r_wsize;
    logic [1:0]  r_rburst, r_wburst;
    logic        r_werr;

    logic w_ar_hs, w_r_hs, w_aw_hs, w_w_hs, w_re, w_wover, w_unused;
    logic [31:0] w_rnext, w_wnext, w_mem_rdata;
    logic [ADDR_WIDTH-1:0] w_ridx;

    assign w_unused   = &{1'b0, axi_wid};
    assign w_ar_hs    = axi_arvalid & axi_arready;
    assign w_r_hs     = axi_rvalid & axi_rready;
    assign w_aw_hs    = axi_awvalid & axi_awready;
    assign w_w_hs     = axi_wvalid & axi_wready;
    assign w_rnext    = next_addr(r_araddr, r_rburst, r_rsize);
    assign w_wnext    = next_addr(r_awaddr, r_wburst, r_wsize);
    assign w_wover    = r_wcnt > {1'b0, r_wlen};
    // Fetch the first word, then prefetch the next word on each accepted beat.
    assign w_re       = (r_rstate == R_FETCH) | (w_r_hs & ~axi_rlast);
    assign w_ridx     = (r_rstate == R_FETCH) ? r_araddr[ADDR_WIDTH+1:2] : w_rnext[ADDR_WIDTH+1:2];

    assign axi_arready = (r_rstate == R_IDLE) & ~rset;
    assign axi_rvalid  = (r_rstate == R_BURST) & ~rset;
    assign axi_rdata   = axi_rvalid ? w_mem_rdata : '0;
    assign axi_rid     = axi_rvalid ? r_rid : '0;
    assign axi_rlast   = axi_rvalid & (r_rcnt == r_rlen);
    assign axi_rresp   = RESP_OKAY;
    assign axi_awready = (r_wstate == W_IDLE) & ~rset;
    assign axi_wready  = (r_wstate == W_DATA) & ~rset;
    assign axi_bvalid  = (r_wstate == W_RESP) & ~rset;
    assign axi_bid     = axi_bvalid ? r_bid : '0;
    assign axi_bresp   = (axi_bvalid & r_werr) ? RESP_SLVERR : RESP_OKAY;

    axi_ram_slave_mem #(.ADDR_WIDTH(ADDR_WIDTH), .INIT_FILE(INIT_FILE)) u_mem (
        .clk     (clk),
        .i_we    (w_w_hs & ~w_wover),
        .i_waddr (r_awaddr[ADDR_WIDTH+1:2]),
        .i_wstrb (axi_wstrb),
        .i_wdata (axi_wdata),
        .i_re    (w_re),
        .i_raddr (w_ridx),
        .o_rdata (w_mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (rset) r_rstate <= R_IDLE;
        else if (w_ar_hs) begin
            r_araddr <= axi_araddr;
            r_rid    <= axi_arid;
            r_rlen   <= axi_arlen;
            r_rsize  <= axi_arsize;
            r_rburst <= axi_arburst;
            r_rcnt   <= '0;
            r_rstate <= R_FETCH;
        end else if (r_rstate == R_FETCH) r_rstate <= R_BURST;
        else if (w_r_hs) begin
            if (axi_rlast) r_rstate <= R_IDLE;
            else begin
                r_araddr <= w_rnext;
                r_rcnt   <= r_rcnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rset) r_wstate <= W_IDLE;
        else if (w_aw_hs) begin
            r_awaddr <= axi_awaddr;
            r_bid    <= axi_awid;
            r_wlen   <= axi_awlen;
            r_wsize  <= axi_awsize;
            r_wburst <= axi_awburst;
            r_wcnt   <= '0;
            r_werr   <= 1'b0;
            r_wstate <= W_DATA;
        end else if (w_w_hs) begin
            r_awaddr <= w_wnext;
            if (!w_wover) r_wcnt <= r_wcnt + 9'd1;
            if (w_wover || (axi_wlast && r_wcnt != {1'b0, r_wlen})) r_werr <= 1'b1;
            if (axi_wlast) r_wstate <= W_RESP;
        end else if (axi_bvalid && axi_bready) r_wstate <= W_IDLE;
    end
endmodule
